// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the unified-memory arbiter of the multicycle MIPS core.
//   state_t  : arbiter FSM states (idle arbitration / memory access)
//   owner_t  : which requester owns the memory (CPU datapath or debug port)
//   cnt_w()  : width of the wait-state counter for a given latency
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // The encoding doubles as the port index of the per-port output vectors.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    localparam int N_PORTS = 2;

    // Counter must hold WAIT_CYCLES-1; one extra value keeps WAIT_CYCLES=1
    // at a legal width of one bit.
    function automatic int cnt_w(input int wait_cycles);
        return $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
// Bundle of the CPU port, the debug/loader port and the memory side of the
// arbiter.
//   modport slave  : the arbiter (consumes requests and mem_rd, drives the
//                    strobes, read data and the memory command)
//   modport master : requesters plus memory model (the opposite direction)
// Parameters: AW address width (byte address), DW data width.
// ----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    // CPU datapath port
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wd;
    logic [DW-1:0] cpu_rd;
    logic          cpu_ready;
    // Debug / loader port
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wd;
    logic [DW-1:0] dbg_rd;
    logic          dbg_ack;
    // Memory side
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd,
        output cpu_rd, cpu_ready,
        input  dbg_req, dbg_we, dbg_addr, dbg_wd,
        output dbg_rd, dbg_ack,
        output mem_en, mem_we, mem_addr, mem_wd,
        input  mem_rd
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wd,
        input  cpu_rd, cpu_ready,
        output dbg_req, dbg_we, dbg_addr, dbg_wd,
        input  dbg_rd, dbg_ack,
        input  mem_en, mem_we, mem_addr, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// ----------------------------------------------------------------------------
// arb_pick
// Combinational winner selection between the CPU and debug requests.
// Build option: MEM_ARB_DBG_PRIO_EN
//   defined   : fixed priority, the debug port wins a tie; i_last is ignored
//   undefined : round-robin, a tie goes to the port that did not win last
// Ports:
//   i_cpu_req, i_dbg_req : raw requests
//   i_last               : previous winner
//   o_grant              : at least one request present
//   o_winner             : selected port (meaningful only with o_grant)
// ----------------------------------------------------------------------------
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_cpu_req,
    input  logic   i_dbg_req,
    input  owner_t i_last,
    output logic   o_grant,
    output owner_t o_winner
);

    assign o_grant = i_cpu_req | i_dbg_req;

`ifdef MEM_ARB_DBG_PRIO_EN
    // History is still tracked by the top level but plays no part here.
    logic w_unused_last;
    assign w_unused_last = i_last;

    always_comb begin
        o_winner = i_dbg_req ? OWN_DBG : OWN_CPU;
    end
`else
    always_comb begin
        o_winner = OWN_CPU;
        if (i_cpu_req && i_dbg_req) begin
            o_winner = (i_last == OWN_CPU) ? OWN_DBG : OWN_CPU;
        end else if (i_dbg_req) begin
            o_winner = OWN_DBG;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Serialises CPU and debug accesses onto the single unified memory, holds the
// memory command for WAIT_CYCLES cycles and returns a one-cycle completion
// strobe (cpu_ready / dbg_ack) to the port that owned the access.
// Build option MEM_ARB_DBG_PRIO_EN selects fixed debug priority (see arb_pick).
// Parameters: AW, DW widths; WAIT_CYCLES memory latency, legal 1..15.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (both requester ports and the memory side)
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int               CNT_W    = cnt_w(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_next;
    owner_t          r_owner;
    owner_t          r_last;
    owner_t          w_winner;
    logic            w_grant;
    logic            w_done;
    logic            w_active;
    logic [CNT_W-1:0] r_cnt;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wd;

    logic [N_PORTS-1:0] w_strobe;
    logic [DW-1:0]      w_rd [N_PORTS];

    arb_pick u_pick (
        .i_cpu_req (bus.cpu_req),
        .i_dbg_req (bus.dbg_req),
        .i_last    (r_last),
        .o_grant   (w_grant),
        .o_winner  (w_winner)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Final wait cycle: strobe the owner and release the memory.
                if (r_cnt == '0) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------- command latch, owner, counter -------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner <= OWN_CPU;
            r_last  <= OWN_DBG;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wd    <= '0;
        end else if (r_state == ST_IDLE && w_grant) begin
            // Command is captured once; later changes on the ports are ignored.
            r_owner <= w_winner;
            r_cnt   <= CNT_LOAD;
            if (w_winner == OWN_DBG) begin
                r_we   <= bus.dbg_we;
                r_addr <= bus.dbg_addr;
                r_wd   <= bus.dbg_wd;
            end else begin
                r_we   <= bus.cpu_we;
                r_addr <= bus.cpu_addr;
                r_wd   <= bus.cpu_wd;
            end
        end else if (r_state == ST_ACCESS) begin
            if (w_done) begin
                r_last <= r_owner;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // ---------------- outputs ----------------
    // Memory enables decode straight from state so an asynchronous reset
    // removes them in the same cycle.
    assign w_active     = (r_state == ST_ACCESS);
    assign bus.mem_en   = w_active;
    assign bus.mem_we   = w_active & r_we;
    assign bus.mem_addr = r_addr;
    assign bus.mem_wd   = r_wd;

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign w_strobe[gi] = w_done && (r_owner == owner_t'(1'(gi)));
            assign w_rd[gi]     = (w_active && (r_owner == owner_t'(1'(gi))))
                                  ? bus.mem_rd : '0;
        end
    endgenerate

    assign bus.cpu_ready = w_strobe[OWN_CPU];
    assign bus.dbg_ack   = w_strobe[OWN_DBG];
    assign bus.cpu_rd    = w_rd[OWN_CPU];
    assign bus.dbg_rd    = w_rd[OWN_DBG];

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiters (WAIT_CYCLES=1 and WAIT_CYCLES=3) share one clock and reset and
// are checked every cycle against a transaction-level reference model. Table
// rows drive single accesses, hand sequences cover reset, held ties, reset
// mid-access and dropped requests, and a random phase finishes the run.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus variables, index 0 -> W=1, 1 -> W=3 ----------------
    logic [1:0]  cpu_req_v = '0, cpu_we_v = '0, dbg_req_v = '0, dbg_we_v = '0;
    logic [31:0] cpu_addr_v [2] = '{32'h0, 32'h0};
    logic [31:0] cpu_wd_v   [2] = '{32'h0, 32'h0};
    logic [31:0] dbg_addr_v [2] = '{32'h0, 32'h0};
    logic [31:0] dbg_wd_v   [2] = '{32'h0, 32'h0};

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h4) return 32'h8C01_0008;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic int wc(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    mem_arbiter_if #(.AW(32), .DW(32)) bus1 ();
    mem_arbiter_if #(.AW(32), .DW(32)) bus3 ();

    assign bus1.cpu_req = cpu_req_v[0];  assign bus3.cpu_req = cpu_req_v[1];
    assign bus1.cpu_we  = cpu_we_v[0];   assign bus3.cpu_we  = cpu_we_v[1];
    assign bus1.cpu_addr = cpu_addr_v[0]; assign bus3.cpu_addr = cpu_addr_v[1];
    assign bus1.cpu_wd  = cpu_wd_v[0];   assign bus3.cpu_wd  = cpu_wd_v[1];
    assign bus1.dbg_req = dbg_req_v[0];  assign bus3.dbg_req = dbg_req_v[1];
    assign bus1.dbg_we  = dbg_we_v[0];   assign bus3.dbg_we  = dbg_we_v[1];
    assign bus1.dbg_addr = dbg_addr_v[0]; assign bus3.dbg_addr = dbg_addr_v[1];
    assign bus1.dbg_wd  = dbg_wd_v[0];   assign bus3.dbg_wd  = dbg_wd_v[1];
    assign bus1.mem_rd  = memf(bus1.mem_addr);
    assign bus3.mem_rd  = memf(bus3.mem_addr);

    mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

    logic        o_en [2], o_we [2], o_crdy [2], o_dack [2];
    logic [31:0] o_addr [2], o_wd [2], o_crd [2], o_drd [2];
    assign o_en[0] = bus1.mem_en;      assign o_en[1] = bus3.mem_en;
    assign o_we[0] = bus1.mem_we;      assign o_we[1] = bus3.mem_we;
    assign o_crdy[0] = bus1.cpu_ready; assign o_crdy[1] = bus3.cpu_ready;
    assign o_dack[0] = bus1.dbg_ack;   assign o_dack[1] = bus3.dbg_ack;
    assign o_addr[0] = bus1.mem_addr;  assign o_addr[1] = bus3.mem_addr;
    assign o_wd[0] = bus1.mem_wd;      assign o_wd[1] = bus3.mem_wd;
    assign o_crd[0] = bus1.cpu_rd;     assign o_crd[1] = bus3.cpu_rd;
    assign o_drd[0] = bus1.dbg_rd;     assign o_drd[1] = bus3.dbg_rd;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // m_left = access cycles still to run including the current one (0: idle).
    int          m_left [2];
    int          m_own  [2];   // 0 CPU, 1 DBG
    int          m_last [2];
    logic        m_we   [2];
    logic [31:0] m_addr [2], m_wd [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_left[d] = 0; m_own[d] = 0; m_last[d] = 1;
            m_we[d] = 1'b0; m_addr[d] = '0; m_wd[d] = '0;
        end
    endtask

    task automatic model_edge();
        int w;
        for (int d = 0; d < 2; d++) begin
            if (m_left[d] > 0) begin
                if (m_left[d] == 1) m_last[d] = m_own[d];
                m_left[d] = m_left[d] - 1;
            end else if (cpu_req_v[d] || dbg_req_v[d]) begin
                if (cpu_req_v[d] && dbg_req_v[d]) begin
`ifdef MEM_ARB_DBG_PRIO_EN
                    w = 1;
`else
                    w = 1 - m_last[d];
`endif
                end else begin
                    w = dbg_req_v[d] ? 1 : 0;
                end
                m_own[d]  = w;
                m_we[d]   = (w == 1) ? dbg_we_v[d]   : cpu_we_v[d];
                m_addr[d] = (w == 1) ? dbg_addr_v[d] : cpu_addr_v[d];
                m_wd[d]   = (w == 1) ? dbg_wd_v[d]   : cpu_wd_v[d];
                m_left[d] = wc(d);
            end
        end
    endtask

    task automatic compare_all();
        logic act; logic [31:0] rd;
        for (int d = 0; d < 2; d++) begin
            act = (m_left[d] > 0);
            rd  = memf(m_addr[d]);
            check($sformatf("w%0d.mem_en", wc(d)),    32'(o_en[d]),   32'(act));
            check($sformatf("w%0d.mem_we", wc(d)),    32'(o_we[d]),   32'(act & m_we[d]));
            check($sformatf("w%0d.mem_addr", wc(d)),  o_addr[d],      m_addr[d]);
            check($sformatf("w%0d.mem_wd", wc(d)),    o_wd[d],        m_wd[d]);
            check($sformatf("w%0d.cpu_ready", wc(d)), 32'(o_crdy[d]), 32'(m_left[d] == 1 && m_own[d] == 0));
            check($sformatf("w%0d.dbg_ack", wc(d)),   32'(o_dack[d]), 32'(m_left[d] == 1 && m_own[d] == 1));
            check($sformatf("w%0d.cpu_rd", wc(d)),    o_crd[d], (act && m_own[d] == 0) ? rd : 32'h0);
            check($sformatf("w%0d.dbg_rd", wc(d)),    o_drd[d], (act && m_own[d] == 1) ? rd : 32'h0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_edge();
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        for (int i = 0; i < 2; i++) step();
        reset = 1'b1;
    endtask

    // ---------------- table-driven single accesses ----------------
    typedef struct {
        logic        cpu_req, cpu_we, dbg_req, dbg_we;
        logic [31:0] cpu_addr, cpu_wd, dbg_addr, dbg_wd;
        int          exp_own;
    } vec_t;

    function automatic vec_t mkv(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                                 input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                                 input int own_rr, input int own_prio);
        vec_t v;
        v.cpu_req = cr; v.cpu_we = cw; v.cpu_addr = ca; v.cpu_wd = cd;
        v.dbg_req = dr; v.dbg_we = dw; v.dbg_addr = da; v.dbg_wd = dd;
`ifdef MEM_ARB_DBG_PRIO_EN
        v.exp_own = own_prio;
`else
        v.exp_own = own_rr;
`endif
        return v;
    endfunction

    task automatic drive(input int d, input vec_t v);
        cpu_req_v[d] = v.cpu_req; cpu_we_v[d] = v.cpu_we; cpu_addr_v[d] = v.cpu_addr; cpu_wd_v[d] = v.cpu_wd;
        dbg_req_v[d] = v.dbg_req; dbg_we_v[d] = v.dbg_we; dbg_addr_v[d] = v.dbg_addr; dbg_wd_v[d] = v.dbg_wd;
    endtask

    task automatic idle_inputs(input int d);
        cpu_req_v[d] = 1'b0; dbg_req_v[d] = 1'b0; cpu_we_v[d] = 1'b0; dbg_we_v[d] = 1'b0;
    endtask

    // Holds the request until the first strobe, then checks winner, latency and data.
    task automatic run_row(input int d, input vec_t v, input string tag);
        int seen, lat;
        logic [31:0] rd_seen;
        seen = -1; lat = 0; rd_seen = '0;
        drive(d, v);
        for (int c = 0; c < wc(d) + 4; c++) begin
            step();
            lat++;
            if (o_crdy[d] || o_dack[d]) begin
                seen    = o_dack[d] ? 1 : 0;
                rd_seen = o_dack[d] ? o_drd[d] : o_crd[d];
                break;
            end
        end
        idle_inputs(d);
        check($sformatf("%s.w%0d.owner", tag, wc(d)),   32'(seen), 32'(v.exp_own));
        check($sformatf("%s.w%0d.latency", tag, wc(d)), 32'(lat),  32'(wc(d)));
        check($sformatf("%s.w%0d.rd", tag, wc(d)), rd_seen,
              memf(v.exp_own == 1 ? v.dbg_addr : v.cpu_addr));
        step();
    endtask

    vec_t tbl [9];

    initial begin
        int seq [4];
        int n, strobes;
        vec_t v;

        tbl[0] = mkv(1, 0, 32'h04, 32'h0,         0, 0, 32'h00, 32'h0,         0, 0);
        tbl[1] = mkv(0, 0, 32'h00, 32'h0,         1, 1, 32'h40, 32'hDEADBEEF,  1, 1);
        tbl[2] = mkv(1, 0, 32'h08, 32'h0,         1, 0, 32'h10, 32'h0,         0, 1);
        tbl[3] = mkv(1, 1, 32'h0C, 32'h11111111,  1, 0, 32'h14, 32'h0,         1, 1);
        tbl[4] = mkv(1, 0, 32'h18, 32'h0,         1, 1, 32'h1C, 32'h22222222,  0, 1);
        tbl[5] = mkv(1, 1, 32'h20, 32'h33333333,  0, 0, 32'h00, 32'h0,         0, 0);
        tbl[6] = mkv(1, 0, 32'h24, 32'h0,         1, 0, 32'h28, 32'h0,         1, 1);
        tbl[7] = mkv(0, 0, 32'h00, 32'h0,         1, 0, 32'h2C, 32'h0,         1, 1);
        tbl[8] = mkv(1, 0, 32'h30, 32'h0,         1, 1, 32'h34, 32'h44444444,  0, 1);

        // ---- reset held for 3 cycles, then idle with no requests ----
        model_reset();
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1;
        compare_all();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst.w%0d.outputs_or", wc(d)),
                  32'(o_en[d] | o_we[d] | o_crdy[d] | o_dack[d]) | o_addr[d] | o_wd[d] | o_crd[d] | o_drd[d],
                  32'h0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // ---- table rows on each arbiter in turn ----
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 9; r++)
                run_row(d, tbl[r], $sformatf("row%0d", r));

        // ---- reset in the 2nd cycle of a W=3 debug write ----
        dbg_req_v[1] = 1'b1; dbg_we_v[1] = 1'b1; dbg_addr_v[1] = 32'h40; dbg_wd_v[1] = 32'hDEADBEEF;
        step();
        check("midrst.cycle1.mem_we",   32'(o_we[1]), 32'h1);
        check("midrst.cycle1.mem_addr", o_addr[1],    32'h40);
        step();
        idle_inputs(1);
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst.mem_en_drop", 32'(o_en[1]),   32'h0);
        check("midrst.mem_we_drop", 32'(o_we[1]),   32'h0);
        check("midrst.no_ack",      32'(o_dack[1]), 32'h0);
        compare_all();
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst.after.no_ack", 32'(o_dack[1]), 32'h0);
        end
        run_row(1, tbl[0], "midrst.next");

        // ---- request dropped right after grant ----
        cpu_req_v[1] = 1'b1; cpu_we_v[1] = 1'b0; cpu_addr_v[1] = 32'h48;
        step();
        idle_inputs(1);
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (o_crdy[1]) strobes++;
        end
        check("drop.strobe_count", 32'(strobes), 32'h1);
        check("drop.mem_en_idle",  32'(o_en[1]), 32'h0);

        // ---- both ports request continuously after reset ----
        for (int d = 0; d < 2; d++) begin
            apply_reset();
            cpu_req_v[d] = 1'b1; cpu_addr_v[d] = 32'h100;
            dbg_req_v[d] = 1'b1; dbg_addr_v[d] = 32'h200;
            for (int i = 0; i < 4; i++) seq[i] = -1;
            n = 0;
            for (int c = 0; c < 4 * (wc(d) + 1) + 6 && n < 4; c++) begin
                step();
                if (o_crdy[d])      begin seq[n] = 0; n++; end
                else if (o_dack[d]) begin seq[n] = 1; n++; end
            end
            idle_inputs(d);
            for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_DBG_PRIO_EN
                check($sformatf("held.w%0d.grant%0d", wc(d), i), 32'(seq[i]), 32'h1);
`else
                check($sformatf("held.w%0d.grant%0d", wc(d), i), 32'(seq[i]), 32'(i % 2));
`endif
            end
            for (int i = 0; i < 5; i++) step();
        end

        // ---- random traffic on both arbiters against the model ----
        for (int c = 0; c < 800; c++) begin
            for (int d = 0; d < 2; d++) begin
                cpu_req_v[d]  = ($urandom_range(0, 2) != 0);
                dbg_req_v[d]  = ($urandom_range(0, 2) != 0);
                cpu_we_v[d]   = 1'($urandom_range(0, 1));
                dbg_we_v[d]   = 1'($urandom_range(0, 1));
                cpu_addr_v[d] = 32'($urandom_range(0, 255)) << 2;
                dbg_addr_v[d] = 32'($urandom_range(0, 255)) << 2;
                cpu_wd_v[d]   = $urandom;
                dbg_wd_v[d]   = $urandom;
            end
            step();
        end
        idle_inputs(0);
        idle_inputs(1);
        for (int i = 0; i < 5; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
